fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter that lets two producers share the single write port of the on-chip byte FIFO.
- Grant is held by a registered state machine, with burst-length fairness.
- Data passes through combinationally (zero-latency transfer once granted).
- Honours the FIFO full flag so no word is ever lost or written into a full buffer.

Parameters:
- DATA_WIDTH, 8, width of producer and FIFO data words.
- BURST_MAX, 4, max consecutive words accepted from one requester while the other is waiting (legal range 1..15).
- BURST_W, 4, width of burst counter; must hold BURST_MAX.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0_valid  input  1  producer 0 has a word
- req0_data  input  DATA_WIDTH  producer 0 word
- req0_ready  output  1  producer 0 word accepted this cycle
- req1_valid  input  1  producer 1 has a word
- req1_data  input  DATA_WIDTH  producer 1 word
- req1_ready  output  1  producer 1 word accepted this cycle
- fifo_full  input  1  FIFO cannot accept a write this cycle
- fifo_wr_en  output  1  write strobe to FIFO
- fifo_wr_data  output  DATA_WIDTH  write data to FIFO
- grant  output  2  one-hot current owner (01=req0, 10=req1, 00=none)
- busy  output  1  grant != 00

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-burst):
  - state IDLE, grant=00, busy=0, burst_cnt=0.
  - last_owner=1, so req0 wins the first tie.
  - fifo_wr_en, req0_ready and req1_ready are 0 immediately (they are combinational from grant).
  - fifo_wr_data=0 while grant=00.
  - A word presented during reset is not written.
- Handshake:
  - Transfer happens in a cycle where grant[n]=1, reqn_valid=1 and fifo_full=0.
  - In that cycle: reqn_ready=1, fifo_wr_en=1, fifo_wr_data=reqn_data.
  - Producers hold valid/data stable until ready is seen.
  - Non-granted ready is always 0.
- States IDLE, G0, G1:
  - IDLE: no valid → stay. Only one valid → go to its G. Both valid → go to the one != last_owner. On entry: burst_cnt=0, last_owner updated.
  - Latency: valid rising in IDLE → first write exactly one cycle later (grant registers on the edge).
  - Gn, each accepted word: burst_cnt+1.
  - Gn, reqn_valid=0 at the edge: go to other G if other valid, else IDLE. burst_cnt=0.
  - Gn, accepted word makes burst_cnt reach BURST_MAX and other valid: switch to other G next cycle, burst_cnt=0.
  - Gn, burst_cnt reaches BURST_MAX and other idle: stay in Gn, burst_cnt=0 (no bubble).
- fifo_full stall:
  - No transfer and burst_cnt held.
  - Grant held even if the other requester is waiting; switch only via the rules above.
  - A full→not-full edge resumes with the same owner, with no lost or duplicated word.
- Simultaneous: handover never produces two writes in one cycle; on a switch the old owner's last word is written in the last Gn cycle and the new owner's first word in the first cycle of the new G.
- burst_cnt arithmetic is unsigned BURST_W bits and never exceeds BURST_MAX.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds outputs count0 and count1, 16 bits each, counting accepted words per requester; they wrap at 0xFFFF→0 and reset to 0.
  - Adds output stall_cnt, 16 bits, counting cycles with busy=1, granted valid=1 and fifo_full=1; it saturates at 0xFFFF.
- Undefined: these ports and registers do not exist; core behaviour is identical.

Test Plan:
- Reset, then req0_valid=1 only, data 0x11,0x22,0x33 → cycle 1 grant=01, writes of 0x11,0x22,0x33 on consecutive cycles; req1_ready=0 throughout.
- Both valid continuously, BURST_MAX=4 → write order is 4 words req0, 4 words req1, 4 words req0; no idle cycle between bursts; grant toggles 01→10→01.
- Owner req0 mid-burst (2 words done), fifo_full=1 for 3 cycles, req1 valid → no writes, grant stays 01, burst_cnt=2. After full drops, 2 more req0 words, then switch to req1.
- req1 alone streams 10 words, req0 idle → grant stays 10 the entire time, 10 back-to-back writes, burst_cnt wraps 0..3 repeatedly.
- rst_n pulsed low asynchronously mid-transfer (between edges) → fifo_wr_en and grant go 0 before the next edge; after release, both valid → req0 granted first.
- With FIFO_ARB_STATS_EN: 5 req0 words, 3 req1 words, 2 full-stall cycles → count0=5, count1=3, stall_cnt=2.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle shared by two producers, the arbiter and the FIFO write port.
// master = producer/FIFO side (bench), slave = arbiter side.
interface fifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  req0_valid;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic [1:0]            grant;
    logic                  busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        input  req0_ready, req1_ready, fifo_wr_en, fifo_wr_data, grant, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
        output req0_ready, req1_ready, fifo_wr_en, fifo_wr_data, grant, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Two-producer round-robin write arbiter with burst fairness for the byte FIFO.
// Optional FIFO_ARB_STATS_EN adds per-requester word counters and a stall counter.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int BURST_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_write_arbiter_if.slave bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]         count0,
    output logic [15:0]         count1,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(BURST_MAX);

    state_t               state;
    logic [1:0]           grant_q;
    logic                 busy_q;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 last_owner;

    logic                 xfer0;
    logic                 xfer1;
    logic [BURST_W-1:0]   burst_inc;
    logic                 burst_done;
    logic [DATA_WIDTH-1:0] wr_data;

    // Transfer qualifiers are combinational from the registered grant so a
    // reset clears every strobe without waiting for a clock edge.
    assign xfer0      = grant_q[0] & bus.req0_valid & ~bus.fifo_full;
    assign xfer1      = grant_q[1] & bus.req1_valid & ~bus.fifo_full;
    assign burst_inc  = burst_cnt + BURST_W'(1);
    assign burst_done = (burst_inc == BURST_LIMIT);

    always_comb begin
        wr_data = '0;
        if (grant_q[0]) begin
            wr_data = bus.req0_data;
        end else if (grant_q[1]) begin
            wr_data = bus.req1_data;
        end
    end

    assign bus.req0_ready   = xfer0;
    assign bus.req1_ready   = xfer1;
    assign bus.fifo_wr_en   = xfer0 | xfer1;
    assign bus.fifo_wr_data = wr_data;
    assign bus.grant        = grant_q;
    assign bus.busy         = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_q    <= 2'b00;
            busy_q     <= 1'b0;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    // On a tie the requester that did not own the port last wins.
                    if (bus.req0_valid && (!bus.req1_valid || last_owner)) begin
                        state      <= G0;
                        grant_q    <= 2'b01;
                        busy_q     <= 1'b1;
                        last_owner <= 1'b0;
                    end else if (bus.req1_valid) begin
                        state      <= G1;
                        grant_q    <= 2'b10;
                        busy_q     <= 1'b1;
                        last_owner <= 1'b1;
                    end
                end

                G0: begin
                    if (!bus.req0_valid) begin
                        burst_cnt <= '0;
                        if (bus.req1_valid) begin
                            state      <= G1;
                            grant_q    <= 2'b10;
                            last_owner <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            grant_q <= 2'b00;
                            busy_q  <= 1'b0;
                        end
                    end else if (!bus.fifo_full) begin
                        if (burst_done) begin
                            burst_cnt <= '0;
                            if (bus.req1_valid) begin
                                state      <= G1;
                                grant_q    <= 2'b10;
                                last_owner <= 1'b1;
                            end
                        end else begin
                            burst_cnt <= burst_inc;
                        end
                    end
                end

                G1: begin
                    if (!bus.req1_valid) begin
                        burst_cnt <= '0;
                        if (bus.req0_valid) begin
                            state      <= G0;
                            grant_q    <= 2'b01;
                            last_owner <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            grant_q <= 2'b00;
                            busy_q  <= 1'b0;
                        end
                    end else if (!bus.fifo_full) begin
                        if (burst_done) begin
                            burst_cnt <= '0;
                            if (bus.req0_valid) begin
                                state      <= G0;
                                grant_q    <= 2'b01;
                                last_owner <= 1'b0;
                            end
                        end else begin
                            burst_cnt <= burst_inc;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    grant_q   <= 2'b00;
                    busy_q    <= 1'b0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic stall_cycle;

    assign stall_cycle = busy_q & bus.fifo_full &
                         ((grant_q[0] & bus.req0_valid) | (grant_q[1] & bus.req1_valid));

    // Word counters wrap naturally; the stall counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count0    <= '0;
            count1    <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer0) begin
                count0 <= count0 + 16'd1;
            end
            if (xfer1) begin
                count1 <= count1 + 16'd1;
            end
            if (stall_cycle && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized scoreboard bench for fifo_write_arbiter against a rule-level reference model.
module tb_fifo_write_arbiter;
    localparam int DW   = 8;
    localparam int BMAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] count0, count1, stall_cnt;
`endif

    fifo_write_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BMAX), .BURST_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FIFO_ARB_STATS_EN
        ,
        .count0    (count0),
        .count1    (count1),
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int          src;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   nchk  = 0;
    int   npass = 0;
    bit   chk_en = 1'b0;

    // Reference model: owner (-1 none), words taken in current burst, last owner.
    int m_owner = -1;
    int m_burst = 0;
    int m_last  = 1;
    int m_cnt0  = 0;
    int m_cnt1  = 0;
    int m_stall = 0;

    bit s_v0, s_v1, s_full, acc0, acc1;
    int pv0, pv1, pfull;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic void model_reset();
        m_owner = -1; m_burst = 0; m_last = 1;
        m_cnt0 = 0; m_cnt1 = 0; m_stall = 0;
    endfunction

    function automatic void model_tick();
        int  oth;
        bit  vown, voth;
        if (m_owner < 0) begin
            if (s_v0 && s_v1) m_owner = (m_last == 0) ? 1 : 0;
            else if (s_v0)    m_owner = 0;
            else if (s_v1)    m_owner = 1;
            if (m_owner >= 0) begin
                m_last  = m_owner;
                m_burst = 0;
            end
        end else begin
            oth  = 1 - m_owner;
            vown = (m_owner == 0) ? s_v0 : s_v1;
            voth = (oth == 0) ? s_v0 : s_v1;
            if (!vown) begin
                m_burst = 0;
                m_owner = voth ? oth : -1;
                if (voth) m_last = oth;
            end else if (!s_full) begin
                m_burst++;
                if (m_burst == BMAX) begin
                    m_burst = 0;
                    if (voth) begin
                        m_owner = oth;
                        m_last  = oth;
                    end
                end
            end
        end
    endfunction

    task automatic drive();
        exp_t e;
        bit   vown;
        if (bus.req0_valid) begin
            if (acc0) begin
                bus.req0_valid = ($urandom_range(99) < pv0);
                bus.req0_data  = DW'($urandom);
            end
        end else if ($urandom_range(99) < pv0) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = DW'($urandom);
        end
        if (bus.req1_valid) begin
            if (acc1) begin
                bus.req1_valid = ($urandom_range(99) < pv1);
                bus.req1_data  = DW'($urandom);
            end
        end else if ($urandom_range(99) < pv1) begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = DW'($urandom);
        end
        bus.fifo_full = ($urandom_range(99) < pfull);

        vown = (m_owner == 0) ? bus.req0_valid : (m_owner == 1) ? bus.req1_valid : 1'b0;
        if (vown && !bus.fifo_full) begin
            e.src  = m_owner;
            e.data = (m_owner == 0) ? bus.req0_data : bus.req1_data;
            exp_q.push_back(e);
            if (m_owner == 0) m_cnt0++;
            else              m_cnt1++;
        end else if (vown) begin
            m_stall++;
        end
    endtask

    task automatic sample();
        s_v0   = bus.req0_valid;
        s_v1   = bus.req1_valid;
        s_full = bus.fifo_full;
        acc0   = bus.req0_ready;
        acc1   = bus.req1_ready;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1 drive();
        @(negedge clk);
        sample();
    endtask

    task automatic run_phase(input int a, input int b, input int f, input int n);
        pv0 = a; pv1 = b; pfull = f;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(bus.fifo_wr_en == 1'b0, {tag, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
        check(bus.grant == 2'b00, {tag, "_grant"}, 32'(bus.grant), 0);
        check(bus.busy == 1'b0, {tag, "_busy"}, 32'(bus.busy), 0);
        check(!bus.req0_ready && !bus.req1_ready, {tag, "_ready"},
              32'({bus.req1_ready, bus.req0_ready}), 0);
        check(bus.fifo_wr_data == '0, {tag, "_wr_data"}, 32'(bus.fifo_wr_data), 0);
    endtask

    // Asynchronous reset asserted between edges while both producers hold words.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = DW'($urandom);
        bus.req1_valid = 1'b1;
        bus.req1_data  = DW'($urandom);
        bus.fifo_full  = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        acc0 = 1'b0; acc1 = 1'b0;
        sample();
        #1 chk_en = 1'b1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [1:0] eg;
        exp_t       e;
        bit         src_ok;
        if (chk_en) begin
            eg = (m_owner < 0) ? 2'b00 : (m_owner == 0) ? 2'b01 : 2'b10;
            check(bus.grant == eg, "grant", 32'(bus.grant), 32'(eg));
            check(bus.busy == (eg != 2'b00), "busy", 32'(bus.busy), 32'(eg != 2'b00));
            check((bus.fifo_wr_en == (bus.req0_ready | bus.req1_ready)) &&
                  !(bus.req0_ready && bus.req1_ready), "ready_strobe",
                  32'({bus.fifo_wr_en, bus.req1_ready, bus.req0_ready}), 0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                src_ok = (e.src == 0) ? bus.req0_ready : bus.req1_ready;
                check(bus.fifo_wr_en && src_ok && (bus.fifo_wr_data == e.data), "write",
                      32'({bus.fifo_wr_en, src_ok, bus.fifo_wr_data}),
                      32'({2'b11, e.data}));
            end else begin
                check(!bus.fifo_wr_en, "no_write", 32'(bus.fifo_wr_en), 0);
            end
        end
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0;
        bus.fifo_full  = 1'b0;
        pv0 = 0; pv1 = 0; pfull = 0;
        #2 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sample();
        #1 chk_en = 1'b1;

        run_phase(100,   0,  0,    6);   // lone req0 stream, one-cycle grant latency
        run_phase(  0,   0,  0,    4);
        run_phase(100, 100,  0,   30);   // alternating bursts of BMAX
        run_phase(100, 100, 40,   60);   // stalls mid-burst
        run_phase(  0, 100,  0,   20);   // lone req1 stream, no bubbles
        mid_reset();
        run_phase(100, 100,  0,   10);   // req0 wins first tie after reset
        run_phase( 60,  60, 25, 2000);
        run_phase(  0,   0,  0,   12);

`ifdef FIFO_ARB_STATS_EN
        check(count0 == 16'(m_cnt0), "count0", 32'(count0), 32'(16'(m_cnt0)));
        check(count1 == 16'(m_cnt1), "count1", 32'(count1), 32'(16'(m_cnt1)));
        check(stall_cnt == ((m_stall > 65535) ? 16'hFFFF : 16'(m_stall)), "stall_cnt",
              32'(stall_cnt), 32'(m_stall));
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
